axis_fmcw_frame_ctrl: RTL and testbench

Frame-level acquisition controller placed between the FFT core output and the FMCW RTI averager (upbeat/downbeat bin averaging).
- Gates whole FFT frames onto the RTI path under PS control (arm, frame count) and aligns acquisition to frame boundaries.
- Owns the 20-bit RTI configuration word and applies PS updates only between frames, so the averager never sees a mid-frame config change.
- Reports status counters and a done flag.

---
 rtl/axis_fmcw_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_axis_fmcw_frame_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fmcw_frame_ctrl.sv
// ---------------------------------------------------------------------------
// axis_fmcw_frame_ctrl
//
// Frame-level acquisition gate between the FFT core output and the FMCW RTI
// averager. Whole FFT frames are passed to the RTI path only while armed, and
// acquisition always starts on a frame boundary. The RTI configuration word is
// owned here and PS updates are applied only between frames, so the averager
// never sees a config change in the middle of a frame.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   arm                  level: 1 = acquire, 0 = stop at next frame boundary
//   nframes              frames per acquisition (0 = continuous while armed)
//   cfg_shadow/update    PS config candidate and its one-cycle capture strobe
//   s_axis_*             FFT stream in (tuser = bit-reversed bin index)
//   m_axis_*             stream out to the RTI averager
//   cfg_data             RTI config word currently in effect
//   busy, done           status: SYNC/PASS, DONE
//   frame_cnt            frames passed in this acquisition (wraps)
//   drop_cnt             frames discarded (saturates)
// ---------------------------------------------------------------------------
module axis_fmcw_frame_ctrl #(
  parameter int                   TDATA_WIDTH = 24,
  parameter int                   TUSER_WIDTH = 16,
  parameter int                   CFG_WIDTH   = 20,
  parameter logic [CFG_WIDTH-1:0] CFG_RESET   = 20'h2582A
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   arm,
  input  logic [15:0]            nframes,
  input  logic [CFG_WIDTH-1:0]   cfg_shadow,
  input  logic                   cfg_update,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CFG_WIDTH-1:0]   cfg_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, PASS, DONE} state_t;

  state_t               state_q, state_d;
  logic                 bnd_q, bnd_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
  logic [CFG_WIDTH-1:0] pend_q, pend_d;
  logic                 pending_q, pending_d;

  logic        in_pass;
  logic        hs;
  logic        hs_last;
  logic [15:0] frame_inc;

  // Stream path: zero-latency pass-through in PASS, otherwise drain the FFT
  // so it is never stalled by an idle RTI path.
  always_comb begin
    in_pass       = (state_q == PASS);
    s_axis_tready = in_pass ? m_axis_tready : 1'b1;
    m_axis_tvalid = in_pass & s_axis_tvalid;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tuser  = s_axis_tuser;
    m_axis_tlast  = s_axis_tlast;
    hs            = s_axis_tvalid & s_axis_tready;
    hs_last       = hs & s_axis_tlast;
    frame_inc     = frame_cnt_q + 16'd1;
  end

  // Boundary tracker: 1 when the next accepted beat starts a new frame.
  always_comb begin
    bnd_d = bnd_q;
    if (hs) bnd_d = s_axis_tlast;
  end

  // Acquisition FSM and counters.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (hs_last && !in_pass && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
    case (state_q)
      IDLE: if (arm) begin
        frame_cnt_d = 16'd0;
        // A frame ending on the arming cycle was still discarded.
        drop_cnt_d  = hs_last ? 16'd1 : 16'd0;
        state_d     = bnd_q ? PASS : SYNC;
      end
      SYNC: if (hs_last) state_d = PASS;
      PASS: if (hs_last) begin
        frame_cnt_d = frame_inc;
        if (nframes != 16'd0 && frame_inc == nframes) state_d = DONE;
        else if (!arm)                                state_d = IDLE;
      end
      DONE: if (!arm) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Deferred config: capture on strobe, apply only at a frame boundary. A
  // strobe coinciding with the apply cycle wins, so the newest value lands.
  always_comb begin
    pend_d    = cfg_update ? cfg_shadow : pend_q;
    pending_d = pending_q | cfg_update;
    cfg_d     = cfg_q;
    if (pending_q && ((!in_pass && bnd_q) || hs_last)) begin
      cfg_d     = pend_d;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      bnd_q       <= 1'b1;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
      cfg_q       <= CFG_RESET;
      pend_q      <= CFG_RESET;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bnd_q       <= bnd_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      cfg_q       <= cfg_d;
      pend_q      <= pend_d;
      pending_q   <= pending_d;
    end
  end

  assign cfg_data  = cfg_q;
  assign busy      = (state_q == SYNC) || (state_q == PASS);
  assign done      = (state_q == DONE);
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_axis_fmcw_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axis_fmcw_frame_ctrl
//
// Directed sequence of acquisition scenarios with random sample data, random
// source gaps, random config values and random frame sizes. Expected output
// streams are built per frame from the acquisition rules (which frames should
// reach the RTI), and counters/config are predicted arithmetically.
// ---------------------------------------------------------------------------
module tb_axis_fmcw_frame_ctrl;
  localparam int FL = 1024;
  localparam logic [19:0] CFG_RST = 20'h2582A;

  logic        aclk, aresetn, arm, cfg_update;
  logic [15:0] nframes;
  logic [19:0] cfg_shadow, cfg_data;
  logic [23:0] s_axis_tdata, m_axis_tdata;
  logic [15:0] s_axis_tuser, m_axis_tuser;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic        busy, done;
  logic [15:0] frame_cnt, drop_cnt;

  axis_fmcw_frame_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .arm(arm), .nframes(nframes),
    .cfg_shadow(cfg_shadow), .cfg_update(cfg_update),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .cfg_data(cfg_data), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int ntests = 0;
  int nfail  = 0;
  int pt_err = 0;
  int mir_n  = 0;
  bit exp_pass = 0;
  bit gap_en   = 0;
  bit tog_en   = 0;
  bit rnd_en   = 0;
  logic [40:0] exp_q[$];
  logic [40:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // RTI-side ready pattern: fixed, alternating, or random.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (tog_en)      m_axis_tready = ~m_axis_tready;
      else if (rnd_en) m_axis_tready = 1'($urandom_range(1));
    end
  end

  // Output monitor, sampled mid-cycle while inputs are stable.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      if (m_axis_tvalid) begin
        if (s_axis_tready !== m_axis_tready || m_axis_tdata !== s_axis_tdata ||
            m_axis_tuser !== s_axis_tuser || m_axis_tlast !== s_axis_tlast)
          pt_err++;
        if (tog_en) mir_n++;
        if (m_axis_tready) got_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      end
      if (!busy && (m_axis_tvalid || !s_axis_tready)) pt_err++;
    end
  end

  // Present one FFT beat and hold it until accepted. With upd set, a one-cycle
  // cfg_update strobe is issued on the first presentation cycle.
  task automatic send_beat(input int bin, input bit last, input bit upd,
                           input logic [19:0] shd);
    logic [23:0] d;
    bit took;
    int n;
    d = 24'($urandom);
    n = 0;
    if (gap_en && !upd && $urandom_range(3) == 0) begin
      s_axis_tvalid = 1'b0;
      tick(1);
    end
    s_axis_tdata  = d;
    s_axis_tuser  = 16'(bin);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    if (upd) begin
      cfg_shadow = shd;
      cfg_update = 1'b1;
    end
    while (1) begin
      @(negedge aclk);
      took = s_axis_tready;
      @(posedge aclk);
      #1;
      cfg_update = 1'b0;
      if (took) break;
      n++;
      if (n > 200) begin
        chk("hs_timeout", 32'(n), 32'd0);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (exp_pass) exp_q.push_back({d, 16'(bin), last});
  endtask

  task automatic send_range(input int first, input int lastb, input int flen);
    for (int b = first; b <= lastb; b++) send_beat(b, (b == flen - 1), 1'b0, 20'd0);
  endtask

  task automatic check_stream(input string tag);
    int mism;
    int n;
    mism = 0;
    chk({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
    chk({tag, "_data"}, 32'(mism), 32'd0);
    chk({tag, "_passthru"}, 32'(pt_err), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] ry, rz, rr;
    int nf, extra, len;
    aresetn = 1'b0; arm = 1'b0; nframes = 16'd0;
    cfg_shadow = 20'd0; cfg_update = 1'b0;
    s_axis_tdata = 24'd0; s_axis_tuser = 16'd0; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    tick(3);
    aresetn = 1'b1;
    tick(1);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_cfg", 32'(cfg_data), 32'(CFG_RST));
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd1);

    // Boundary start: three frames pass, the fourth is drained in DONE.
    gap_en = 1; nframes = 16'd3; arm = 1'b1;
    tick(1);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int f = 0; f < 3; f++) begin
      exp_pass = 1;
      send_range(0, FL - 1, FL);
    end
    exp_pass = 0;
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    send_range(0, FL - 1, FL);
    chk("t1_drop_after_done", 32'(drop_cnt), 32'd1);
    chk("t1_done_hold", 32'(done), 32'd1);
    check_stream("t1");
    arm = 1'b0;
    tick(2);
    chk("t1_idle_done", 32'(done), 32'd0);

    // Mid-frame arm: rest of the frame is dropped, next frame passes whole.
    nframes = 16'd2;
    send_range(0, 499, FL);
    arm = 1'b1;
    send_range(500, FL - 1, FL);
    chk("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    exp_pass = 1;
    send_range(0, FL - 1, FL);
    send_range(0, FL - 1, FL);
    exp_pass = 0;
    chk("t2_frame_cnt_end", 32'(frame_cnt), 32'd2);
    chk("t2_done", 32'(done), 32'd1);
    check_stream("t2");
    arm = 1'b0;
    tick(2);

    // Backpressure: alternating RTI ready in PASS.
    gap_en = 0; nframes = 16'd1; arm = 1'b1;
    tick(1);
    tog_en = 1; mir_n = 0;
    exp_pass = 1;
    send_range(0, FL - 1, FL);
    exp_pass = 0;
    tog_en = 0; m_axis_tready = 1'b1;
    chk("t3_mirror_seen", 32'(mir_n > FL), 32'd1);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t3_done", 32'(done), 32'd1);
    check_stream("t3");
    arm = 1'b0;
    tick(2);

    // Deferred config, then an update coinciding with the apply point.
    gap_en = 1; nframes = 16'd2; arm = 1'b1;
    ry = 20'($urandom); rz = 20'($urandom) ^ 20'h80000;
    tick(1);
    exp_pass = 1;
    send_range(0, 99, FL);
    send_beat(100, 1'b0, 1'b1, 20'h3203A);
    chk("t4_cfg_midframe", 32'(cfg_data), 32'(CFG_RST));
    send_range(101, FL - 2, FL);
    chk("t4_cfg_pre_last", 32'(cfg_data), 32'(CFG_RST));
    send_beat(FL - 1, 1'b1, 1'b0, 20'd0);
    chk("t4_cfg_applied", 32'(cfg_data), 32'h3203A);
    send_range(0, 9, FL);
    send_beat(10, 1'b0, 1'b1, ry);
    send_range(11, FL - 2, FL);
    chk("t4_cfg_hold2", 32'(cfg_data), 32'h3203A);
    send_beat(FL - 1, 1'b1, 1'b1, rz);
    exp_pass = 0;
    chk("t4_cfg_coincide", 32'(cfg_data), 32'(rz));
    tick(3);
    chk("t4_cfg_stable", 32'(cfg_data), 32'(rz));
    check_stream("t4");
    arm = 1'b0;
    tick(2);
    // Update between frames takes effect one cycle after capture.
    rr = 20'($urandom);
    cfg_shadow = rr; cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    chk("t4_idle_cfg_old", 32'(cfg_data), 32'(rz));
    tick(1);
    chk("t4_idle_cfg_new", 32'(cfg_data), 32'(rr));

    // Continuous mode, arm dropped in the 5th frame.
    nframes = 16'd0; arm = 1'b1;
    tick(1);
    exp_pass = 1;
    for (int f = 0; f < 4; f++) send_range(0, FL - 1, FL);
    send_range(0, 9, FL);
    arm = 1'b0;
    send_range(10, FL - 1, FL);
    exp_pass = 0;
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("t5_busy", 32'(busy), 32'd0);
    send_range(0, FL - 1, FL);
    send_range(0, FL - 1, FL);
    chk("t5_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("t5_frame_hold", 32'(frame_cnt), 32'd5);
    check_stream("t5");

    // Reset in the middle of a passing frame.
    arm = 1'b1;
    tick(1);
    exp_pass = 1;
    send_range(0, FL - 1, FL);
    send_range(0, 299, FL);
    exp_pass = 0;
    chk("t6_frame_pre", 32'(frame_cnt), 32'd1);
    s_axis_tuser = 16'd300; s_axis_tvalid = 1'b1;
    aresetn = 1'b0;
    tick(1);
    chk("t6_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_cfg", 32'(cfg_data), 32'(CFG_RST));
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    s_axis_tvalid = 1'b0; arm = 1'b0;
    aresetn = 1'b1;
    tick(1);
    check_stream("t6");

    // Random short frames, random RTI ready, random acquisition length.
    rnd_en = 1;
    for (int it = 0; it < 3; it++) begin
      nf = $urandom_range(1, 3);
      extra = $urandom_range(1, 2);
      nframes = 16'(nf); arm = 1'b1;
      tick(1);
      for (int f = 0; f < nf + extra; f++) begin
        len = $urandom_range(4, 40);
        exp_pass = (f < nf);
        send_range(0, len - 1, len);
      end
      exp_pass = 0;
      chk("t7_done", 32'(done), 32'd1);
      chk("t7_frame_cnt", 32'(frame_cnt), 32'(nf));
      chk("t7_drop_cnt", 32'(drop_cnt), 32'(extra));
      arm = 1'b0;
      tick(2);
      chk("t7_idle", 32'(done), 32'd0);
      check_stream("t7");
    end
    rnd_en = 0; m_axis_tready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
